gs_clk_select: RTL and testbench

- Clock-output generator that produces `clkout` from a single system clock `clk24in`, with four selectable sources picked by `clksel1:clksel0`.
- Sources are three divided versions of `clk24in`, plus a resampled copy of the external `clk20in` input.
- Changing the selection never produces a runt pulse: the switch waits for a low phase and inserts a guard gap.
- Sits between the board oscillator inputs and downstream logic that needs a switchable clock.

---
 rtl/gs_clk_select_if.sv | 26 ++
 rtl/gs_clk_select.sv | 131 +++++++++++++
 tb/tb_gs_clk_select.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gs_clk_select_if.sv
// Signal bundle for the selectable clock generator: the asynchronous select
// pins, the external reference input and the generated clock output.
`timescale 1ns/1ps

interface gs_clk_select_if;
    logic clk20in;
    logic clksel0;
    logic clksel1;
    logic clkout;

    // Board/driver side: drives the selects and the reference, sees the clock.
    modport master (
        output clk20in,
        output clksel0,
        output clksel1,
        input  clkout
    );

    // Generator side: samples the selects and the reference, drives the clock.
    modport slave (
        input  clk20in,
        input  clksel0,
        input  clksel1,
        output clkout
    );
endinterface

// File: rtl/gs_clk_select.sv
// Glitch-free selectable clock generator. clkout is a flop output derived
// from clk24in: /2, /4, /8, or a resampled copy of clk20in. A source change
// lets the current high phase finish, then holds clkout low for a guard gap
// before restarting the divider on the new source.
`timescale 1ns/1ps

module gs_clk_select #(
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic            clk24in,
    input  logic            coldres,
    gs_clk_select_if.slave  bus
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Selected source value for a given select code, divider count and
    // resampled reference.
    function automatic logic src(input logic [1:0] s, input logic [2:0] c, input logic x);
        logic v;
        case (s)
            2'b00:   v = c[0];
            2'b01:   v = c[1];
            2'b11:   v = c[2];
            2'b10:   v = x;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    logic [SYNC_STAGES-1:0] sel0_sync;
    logic [SYNC_STAGES-1:0] sel1_sync;
    logic [SYNC_STAGES-1:0] c20_sync;
    logic [1:0]             sel_s;
    logic                   c20_s;

    state_t                 state;
    logic [1:0]             cur_sel;
    logic [2:0]             cnt;
    logic [GW-1:0]          gcnt;
    logic                   clkout_r;
    logic                   src_now;

    assign sel_s   = {sel1_sync[SYNC_STAGES-1], sel0_sync[SYNC_STAGES-1]};
    assign c20_s   = c20_sync[SYNC_STAGES-1];
    assign bus.clkout = clkout_r;

    // Resynchronise the asynchronous select pins and the external reference.
    always_ff @(posedge clk24in) begin
        if (coldres) begin
            sel0_sync <= '0;
            sel1_sync <= '0;
            c20_sync  <= '0;
        end else begin
            sel0_sync <= {sel0_sync[SYNC_STAGES-2:0], bus.clksel0};
            sel1_sync <= {sel1_sync[SYNC_STAGES-2:0], bus.clksel1};
            c20_sync  <= {c20_sync[SYNC_STAGES-2:0],  bus.clk20in};
        end
    end

    // Value the current source presents this cycle.
    always_comb begin
        src_now = 1'b0;
        if (state != GAP) begin
            src_now = src(cur_sel, cnt, c20_s);
        end else begin
            src_now = 1'b0;
        end
    end

    // Switch controller: run the selected source, drain its high phase on a
    // select change, hold a low guard gap, then restart on the new source.
    always_ff @(posedge clk24in) begin
        if (coldres) begin
            state    <= RUN;
            cur_sel  <= 2'b00;
            cnt      <= 3'd0;
            gcnt     <= '0;
            clkout_r <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    clkout_r <= src_now;
                    cnt      <= cnt + 3'd1;
                    if (sel_s != cur_sel) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (clkout_r) begin
                        // Let the high phase finish at its natural length.
                        clkout_r <= src_now;
                        cnt      <= cnt + 3'd1;
                    end else begin
                        clkout_r <= 1'b0;
                        gcnt     <= '0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    clkout_r <= 1'b0;
                    if (gcnt == GAP_LAST) begin
                        // Take whatever select is present now, even if it
                        // matches the old one; divider restarts from zero.
                        cur_sel <= sel_s;
                        cnt     <= 3'd0;
                        gcnt    <= '0;
                        state   <= RUN;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                default: begin
                    state    <= RUN;
                    cnt      <= 3'd0;
                    gcnt     <= '0;
                    clkout_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gs_clk_select.sv
// Directed bench for gs_clk_select: reset behaviour, steady periods of each
// divided source, a switch during a high phase, the clk20in path, a rotating
// select run with glitch/gap/stall tracking, and reset during the guard gap.
`timescale 1ns/1ps

module tb_gs_clk_select;

    logic clk24in = 1'b0;
    logic coldres;
    int   checks = 0;
    int   errors = 0;
    int   c20_cnt = 0;

    gs_clk_select_if bus ();

    gs_clk_select #(.SYNC_STAGES(2), .GAP_CYCLES(2)) dut (
        .clk24in (clk24in),
        .coldres (coldres),
        .bus     (bus)
    );

    // 24 MHz system clock
    initial forever #20.833 clk24in = ~clk24in;

    // 1 MHz reference: toggles every 12 clk24in cycles, on the falling edge
    initial begin
        bus.clk20in = 1'b0;
        forever begin
            @(negedge clk24in);
            c20_cnt++;
            if (c20_cnt == 12) begin
                c20_cnt = 0;
                bus.clk20in = ~bus.clk20in;
            end
        end
    end

    // Global time limit
    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk24in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input logic [1:0] s);
        bus.clksel1 = s[1];
        bus.clksel0 = s[0];
    endtask

    // Starting at a sample where clkout just rose: width of this high phase
    // and the following low phase; ends on the next rising sample.
    task automatic measure(output int hi, output int lo, output bit ok);
        hi = 1;
        lo = 1;
        ok = 1'b1;
        tick();
        while (bus.clkout === 1'b1 && hi < 100) begin
            hi++;
            tick();
        end
        tick();
        while (bus.clkout !== 1'b1 && lo < 100) begin
            lo++;
            tick();
        end
        if (hi >= 100 || lo >= 100) ok = 1'b0;
    endtask

    // Number of low samples, starting with the current one, before clkout rises.
    task automatic count_low(output int n);
        n = 0;
        while (bus.clkout !== 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    function automatic int nom(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b11:   return 4;
            default: return 1;
        endcase
    endfunction

    initial begin
        int hi;
        int lo;
        int n;
        int bad;
        bit ok;
        bit found;
        logic prev;
        logic [1:0] cur;
        logic [1:0] nxt;
        int thr;
        int stalls;
        int glitches;
        int nogap;
        bit gap;

        // ---- reset held with select 11
        coldres = 1'b1;
        set_sel(2'b11);
        tick();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.clkout !== 1'b0) bad++;
        end
        chk("reset_low_cycles", bad, 0);
        chk("reset_clkout", bus.clkout, 1'b0);

        // ---- release: /2 toggling until the switch to 11 completes
        coldres = 1'b0;
        tick();
        chk("rel_e1", bus.clkout, 1'b0);
        tick();
        chk("rel_e2", bus.clkout, 1'b1);
        tick();
        chk("rel_e3", bus.clkout, 1'b0);
        count_low(n);
        chk("rel_gap_low", n, 8);
        measure(hi, lo, ok);
        chk("rel_sel11_hi", hi, 4);
        chk("rel_sel11_lo", lo, 4);

        // ---- sel 11 steady: 4 high / 4 low
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            measure(hi, lo, ok);
            if (hi != 4 || lo != 4 || !ok) bad++;
        end
        chk("sel11_periods", bad, 0);

        // ---- switch 11 -> 00 right after a rising edge (cnt=5)
        set_sel(2'b00);
        measure(hi, lo, ok);
        chk("sw11_00_hi", hi, 4);
        chk("sw11_00_lo", lo, 5);

        // ---- sel 00 steady: 1 high / 1 low
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            measure(hi, lo, ok);
            if (hi != 1 || lo != 1 || !ok) bad++;
        end
        chk("sel00_periods", bad, 0);

        // ---- sel 01 steady: 2 high / 2 low
        set_sel(2'b01);
        for (int i = 0; i < 4; i++) measure(hi, lo, ok);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            measure(hi, lo, ok);
            if (hi != 2 || lo != 2 || !ok) bad++;
        end
        chk("sel01_periods", bad, 0);

        // ---- reset during the guard gap of a 01 -> 11 switch
        set_sel(2'b11);
        tick();
        chk("rg_e1", bus.clkout, 1'b1);
        tick();
        chk("rg_e2", bus.clkout, 1'b0);
        tick();
        tick();
        chk("rg_e4", bus.clkout, 1'b0);
        coldres = 1'b1;
        tick();
        chk("rg_reset", bus.clkout, 1'b0);
        coldres = 1'b0;
        tick();
        chk("rg_run_e6", bus.clkout, 1'b0);
        tick();
        chk("rg_run_e7", bus.clkout, 1'b1);
        tick();
        chk("rg_run_e8", bus.clkout, 1'b0);
        count_low(n);
        chk("rg_redetect_low", n, 8);
        measure(hi, lo, ok);
        chk("rg_sel11_hi", hi, 4);
        chk("rg_sel11_lo", lo, 4);

        // ---- sel 10: resampled clk20in, 3-edge delay, 12/12 widths
        set_sel(2'b10);
        for (int i = 0; i < 80; i++) tick();
        found = 1'b0;
        prev = bus.clk20in;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (prev === 1'b0 && bus.clk20in === 1'b1) begin
                found = 1'b1;
                break;
            end
            prev = bus.clk20in;
        end
        chk("c20_edge_found", found, 1'b1);
        chk("c20_d1", bus.clkout, 1'b0);
        tick();
        chk("c20_d2", bus.clkout, 1'b0);
        tick();
        chk("c20_d3", bus.clkout, 1'b1);
        measure(hi, lo, ok);
        chk("c20_hi", hi, 12);
        chk("c20_lo", lo, 12);

        // ---- rotating select, 40 switches, 10 rising edges each
        cur = 2'b10;
        stalls = 0;
        glitches = 0;
        nogap = 0;
        for (int k = 0; k < 40; k++) begin
            nxt = cur + 2'd1;
            set_sel(nxt);
            gap = 1'b0;
            for (int j = 0; j < 10; j++) begin
                measure(hi, lo, ok);
                if (!ok) begin
                    stalls++;
                    break;
                end
                if (j < 3) thr = (nom(cur) < nom(nxt)) ? nom(cur) : nom(nxt);
                else       thr = nom(nxt);
                if (hi < thr) glitches++;
                if (j < 4 && lo >= 3) gap = 1'b1;
            end
            if (!gap) nogap++;
            cur = nxt;
            if (stalls > 0) break;
        end
        chk("rot_stalls", stalls, 0);
        chk("rot_glitches", glitches, 0);
        chk("rot_missing_gap", nogap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
